// File: rtl/gcd_operand_sequencer_if.sv
// Host, result and GCD-core signals of gcd_operand_sequencer bundled together.
// The sequencer uses the slave view; the environment (host + core) uses master.
`timescale 1ns/1ps
interface gcd_operand_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             gcd_start;
  logic [WIDTH-1:0] gcd_data;
  logic             gcd_done;
  logic [WIDTH-1:0] gcd_result;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic [15:0]      res_cycles;
  logic             res_err;

  modport slave (
    input  in_valid, in_a, in_b, gcd_done, gcd_result, res_ready,
    output in_ready, gcd_start, gcd_data,
    output res_valid, res_data, res_a, res_b, res_cycles, res_err
  );

  modport master (
    output in_valid, in_a, in_b, gcd_done, gcd_result, res_ready,
    input  in_ready, gcd_start, gcd_data,
    input  res_valid, res_data, res_a, res_b, res_cycles, res_err
  );
endinterface

// File: rtl/gcd_operand_sequencer.sv
// Operand-pair FIFO plus start/load-A/load-B sequencer driving a subtractive GCD core.
// Optional WAIT watchdog enabled by defining GCD_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module gcd_operand_sequencer #(
  parameter int WIDTH          = 16,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                   clk,
  input logic                   rst_n,
  gcd_operand_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
`ifdef GCD_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_A,
    S_LOAD_B,
    S_WAIT,
    S_RESULT
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW:0]      wr_ptr_reg, rd_ptr_reg;
  logic             full, empty, push, pop;
  logic [WIDTH-1:0] head_a, head_b;
  logic             head_zero;

  logic [WIDTH-1:0] cur_a_reg, cur_b_reg;
  logic [WIDTH-1:0] res_data_reg, res_a_reg, res_b_reg;
  logic [15:0]      res_cycles_reg;
  logic             res_err_reg;
  logic [15:0]      wait_cnt_reg, wait_cnt_inc;
  logic             timeout_reached;

  logic             take_bypass, cnt_clear, capture_done, timeout_hit;
  logic             gcd_start_c, res_valid_c;
  logic [WIDTH-1:0] gcd_data_c;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign push  = bus.in_valid && !full;
  assign bus.in_ready = !full;

  assign head_a    = mem_a[rd_ptr_reg[AW-1:0]];
  assign head_b    = mem_b[rd_ptr_reg[AW-1:0]];
  assign head_zero = (head_a == '0) || (head_b == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_reg[AW-1:0]] <= bus.in_a;
      mem_b[wr_ptr_reg[AW-1:0]] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  assign wait_cnt_inc    = (wait_cnt_reg == 16'hFFFF) ? wait_cnt_reg : wait_cnt_reg + 16'd1;
  assign timeout_reached = TIMEOUT_EN && (32'(wait_cnt_inc) == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    pop          = 1'b0;
    take_bypass  = 1'b0;
    cnt_clear    = 1'b0;
    capture_done = 1'b0;
    timeout_hit  = 1'b0;
    gcd_start_c  = 1'b0;
    gcd_data_c   = '0;
    res_valid_c  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // A zero operand would never terminate the subtractive core.
          if (head_zero) begin
            take_bypass = 1'b1;
            state_next  = S_RESULT;
          end else begin
            state_next  = S_START;
          end
        end
      end
      S_START: begin
        gcd_start_c = 1'b1;
        gcd_data_c  = cur_a_reg;
        state_next  = S_LOAD_A;
      end
      S_LOAD_A: begin
        gcd_data_c = cur_a_reg;
        state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        gcd_data_c = cur_b_reg;
        cnt_clear  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        gcd_data_c = cur_b_reg;
        if (bus.gcd_done) begin
          capture_done = 1'b1;
          state_next   = S_RESULT;
        end else if (timeout_reached) begin
          timeout_hit = 1'b1;
          state_next  = S_RESULT;
        end
      end
      S_RESULT: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_a_reg      <= '0;
      cur_b_reg      <= '0;
      res_data_reg   <= '0;
      res_a_reg      <= '0;
      res_b_reg      <= '0;
      res_cycles_reg <= '0;
      res_err_reg    <= 1'b0;
      wait_cnt_reg   <= '0;
    end else begin
      if (pop) begin
        cur_a_reg <= head_a;
        cur_b_reg <= head_b;
      end
      if (take_bypass) begin
        res_data_reg   <= head_a | head_b;
        res_a_reg      <= head_a;
        res_b_reg      <= head_b;
        res_cycles_reg <= '0;
        res_err_reg    <= 1'b0;
      end
      if (cnt_clear) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == S_WAIT) begin
        wait_cnt_reg <= wait_cnt_inc;
      end
      // The cycle that sees done is itself counted as a WAIT cycle.
      if (capture_done) begin
        res_data_reg   <= bus.gcd_result;
        res_a_reg      <= cur_a_reg;
        res_b_reg      <= cur_b_reg;
        res_cycles_reg <= wait_cnt_inc;
        res_err_reg    <= 1'b0;
      end
      if (timeout_hit) begin
        res_data_reg   <= '0;
        res_a_reg      <= cur_a_reg;
        res_b_reg      <= cur_b_reg;
        res_cycles_reg <= wait_cnt_inc;
        res_err_reg    <= 1'b1;
      end
    end
  end

  assign bus.gcd_start  = gcd_start_c;
  assign bus.gcd_data   = gcd_data_c;
  assign bus.res_valid  = res_valid_c;
  assign bus.res_data   = res_data_reg;
  assign bus.res_a      = res_a_reg;
  assign bus.res_b      = res_b_reg;
  assign bus.res_cycles = res_cycles_reg;
  assign bus.res_err    = res_err_reg;
endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Scoreboard bench for gcd_operand_sequencer with a behavioural subtractive GCD core.
// Timeout scenario runs only when GCD_SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_gcd_operand_sequencer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_operand_sequencer_if #(.WIDTH(WIDTH)) bus();

  gcd_operand_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [15:0] data;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] cycles;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   starts = 0;
  logic core_hang = 1'b0;

  function automatic int gcd_ref(int a, int b);
    int t;
    if (a == 0) return b;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int sub_steps(int a, int b);
    int n = 0;
    if (a == 0 || b == 0) return 0;
    while (a != b) begin
      if (a > b) a = a - b;
      else       b = b - a;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Core: start -> latch A -> latch B -> busy for sub_steps cycles -> done held.
  int          cst;
  int          lat;
  logic [15:0] ca, cb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cst <= 0; lat <= 0; ca <= '0; cb <= '0;
    end else if (bus.gcd_start) begin
      cst <= 1;
    end else begin
      case (cst)
        1: begin ca <= bus.gcd_data; cst <= 2; end
        2: begin cb <= bus.gcd_data; lat <= sub_steps(int'(ca), int'(bus.gcd_data)); cst <= 3; end
        3: if (lat == 0) cst <= 4; else lat <= lat - 1;
        default: ;
      endcase
    end
  end
  assign bus.gcd_done   = !core_hang && ((cst == 3 && lat == 0) || cst == 4);
  assign bus.gcd_result = 16'(gcd_ref(int'(ca), int'(cb)));

  always @(posedge clk) if (rst_n && bus.gcd_start) starts <= starts + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got data=%0d a=%0d b=%0d, expected no result",
                 bus.res_data, bus.res_a, bus.res_b);
      end else begin
        e = exp_q.pop_front();
        $display("result a=%0d b=%0d -> gcd=%0d cycles=%0d err=%0d",
                 bus.res_a, bus.res_b, bus.res_data, bus.res_cycles, bus.res_err);
        check("res_data",   32'(bus.res_data),   32'(e.data));
        check("res_a",      32'(bus.res_a),      32'(e.a));
        check("res_b",      32'(bus.res_b),      32'(e.b));
        check("res_cycles", 32'(bus.res_cycles), 32'(e.cycles));
        check("res_err",    32'(bus.res_err),    32'(e.err));
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b, input bit tmo);
    exp_t e;
    bit   accepted = 0;
    e.a = a;
    e.b = b;
    if (a == 0 || b == 0) begin
      e.data = a | b; e.cycles = 0; e.err = 0;
    end else if (tmo) begin
      e.data = 0; e.cycles = 16'(TMO); e.err = 1;
    end else begin
      e.data = 16'(gcd_ref(int'(a), int'(b)));
      e.cycles = 16'(sub_steps(int'(a), int'(b)) + 1);
      e.err = 0;
    end
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int i = 0; i < 5000 && !accepted; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!accepted) check("push_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    bit drained = 0;
    for (int i = 0; i < budget && !drained; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) drained = 1;
    end
    if (!drained) check("drain_queue", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, "_gcd_start"},  32'(bus.gcd_start),  32'd0);
    check({tag, "_gcd_data"},   32'(bus.gcd_data),   32'd0);
    check({tag, "_res_valid"},  32'(bus.res_valid),  32'd0);
    check({tag, "_res_data"},   32'(bus.res_data),   32'd0);
    check({tag, "_res_a"},      32'(bus.res_a),      32'd0);
    check({tag, "_res_b"},      32'(bus.res_b),      32'd0);
    check({tag, "_res_cycles"}, 32'(bus.res_cycles), 32'd0);
    check({tag, "_res_err"},    32'(bus.res_err),    32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  s0;
    bit  rand_done = 0;
    logic [15:0] ra, rb;

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;

    // (48,18): waveform of the load sequence.
    s0 = starts;
    push(16'd48, 16'd18, 0);
    check("p1_idle_start", 32'(bus.gcd_start), 32'd0);
    @(posedge clk); #1;
    check("p1_start_hi",  32'(bus.gcd_start), 32'd1);
    check("p1_start_data", 32'(bus.gcd_data), 32'd48);
    @(posedge clk); #1;
    check("p1_loada_start", 32'(bus.gcd_start), 32'd0);
    check("p1_loada_data",  32'(bus.gcd_data),  32'd48);
    @(posedge clk); #1;
    check("p1_loadb_data",  32'(bus.gcd_data),  32'd18);
    wait_drain(500);
    check("p1_start_count", 32'(starts - s0), 32'd1);

    // Back-to-back pairs.
    s0 = starts;
    push(16'd323, 16'd120, 0);
    push(16'd9, 16'd9, 0);
    wait_drain(2000);
    check("p2_start_count", 32'(starts - s0), 32'd2);

    // Zero bypass.
    s0 = starts;
    push(16'd0, 16'd35, 0);
    check("p3a_valid_early", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    check("p3a_valid_rise", 32'(bus.res_valid), 32'd1);
    wait_drain(50);
    push(16'd0, 16'd0, 0);
    check("p3b_valid_early", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    check("p3b_valid_rise", 32'(bus.res_valid), 32'd1);
    wait_drain(50);
    check("p3_start_count", 32'(starts - s0), 32'd0);

    // Backpressure: DEPTH queued plus one held in RESULT.
    bus.res_ready = 1'b0;
    push(16'd6, 16'd4, 0);
    push(16'd15, 16'd10, 0);
    push(16'd7, 16'd3, 0);
    push(16'd8, 16'd8, 0);
    push(16'd100, 16'd75, 0);
    repeat (200) @(negedge clk);
    check("p4_full_ready", 32'(bus.in_ready), 32'd0);
    check("p4_held_valid", 32'(bus.res_valid), 32'd1);
    check("p4_held_a",     32'(bus.res_a), 32'd6);
    bus.in_valid = 1'b1;
    bus.in_a = 16'd99;
    bus.in_b = 16'd33;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("p4_full_hold", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    wait_drain(2000);

    // Randomized pairs with random result backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          ra = 16'($urandom_range(1, 255));
          rb = 16'($urandom_range(1, 255));
          if ($urandom_range(0, 7) == 0) ra = '0;
          if ($urandom_range(0, 7) == 0) rb = '0;
          push(ra, rb, 0);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.res_ready = 1'b1;
    wait_drain(20000);

    // Reset during WAIT discards the in-flight pair and the queue.
    push(16'd250, 16'd1, 0);
    push(16'd30, 16'd12, 0);
    push(16'd14, 16'd21, 0);
    repeat (10) @(posedge clk);
    #1;
    check("p6_in_wait_data", 32'(bus.gcd_data), 32'd1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("p6_post_valid", 32'(bus.res_valid), 32'd0);
    check("p6_post_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    push(16'd21, 16'd14, 0);
    wait_drain(500);

`ifdef GCD_SEQ_TIMEOUT_EN
    core_hang = 1'b1;
    push(16'd100, 16'd30, 1);
    wait_drain(500);
    core_hang = 1'b0;
    push(16'd12, 16'd8, 0);
    wait_drain(500);
`endif

    repeat (5) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_res_valid", 32'(bus.res_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
